// File: rtl/operand_recover.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : operand_recover                                              |
// | Brief   : 2-stage valid/ready pipeline recovering b from a and y=a+/-b  |
// |           Optional stats counters: define OPERAND_RECOVER_STATS_EN      |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module operand_recover #(
  parameter int SEL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_a,
  input  logic [7:0]  in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_b,
  output logic        out_err,
  output logic [15:0] cnt_total,
  output logic [15:0] cnt_err
);

  logic       r_s1_valid;
  logic [6:0] r_s1_a;
  logic [7:0] r_s1_y;
  logic       r_s2_valid;
  logic [6:0] r_s2_b;
  logic       r_s2_err;

  logic       w_s1_load;
  logic       w_s2_load;
  logic [6:0] w_b;
  logic       w_err;

  // Ready ripples back from the consumer; in_valid never feeds in_ready.
  assign w_s2_load = !r_s2_valid | out_ready;
  assign w_s1_load = !r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;

  generate
    case (SEL)
      1: begin : g_sub
        logic [7:0] w_d;
        assign w_d   = {1'b0, r_s1_a} - r_s1_y;
        assign w_b   = w_d[6:0];
        assign w_err = w_d[7];
      end
      default: begin : g_add
        logic [8:0] w_d;
        assign w_d   = {1'b0, r_s1_y} - {2'b00, r_s1_a};
        assign w_b   = w_d[6:0];
        assign w_err = w_d[8] | w_d[7];
      end
    endcase
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= 7'd0;
      r_s1_y     <= 8'd0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a <= in_a;
        r_s1_y <= in_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_b     <= 7'd0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_b   <= w_b;
        r_s2_err <= w_err;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_b     = r_s2_b;
  assign out_err   = r_s2_err;

`ifdef OPERAND_RECOVER_STATS_EN
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic        w_out_fire;
  logic [15:0] r_cnt_total;
  logic [15:0] r_cnt_err;

  assign w_out_fire = r_s2_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_total <= 16'd0;
      r_cnt_err   <= 16'd0;
    end else if (w_out_fire) begin
      if (r_cnt_total != c_cnt_max) r_cnt_total <= r_cnt_total + 16'd1;
      if (r_s2_err && (r_cnt_err != c_cnt_max)) r_cnt_err <= r_cnt_err + 16'd1;
    end
  end

  assign cnt_total = r_cnt_total;
  assign cnt_err   = r_cnt_err;
`else
  assign cnt_total = 16'd0;
  assign cnt_err   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_recover.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_operand_recover                                           |
// | Brief   : randomized self-checking bench for operand_recover            |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_operand_recover;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [6:0]  in_a;
  logic [7:0]  in_y;
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [6:0]  out_b     [3];
  logic        out_err   [3];
  logic [15:0] cnt_total [3];
  logic [15:0] cnt_err   [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] exp_q [3][$];
  logic [7:0] got_q [3][$];
  int         del     [3];
  int         del_err [3];
  bit         stalled [3];
  logic [7:0] held    [3];
  bit         collect;
  bit         acc;
  int         first_cyc;
  int         last_cyc;

  always #5 clk = ~clk;

  // Instance 0: adder inverse, 1: subtractor inverse, 2: out-of-range SEL (adder).
  operand_recover #(.SEL(0)) u_add (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_y(in_y), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_b(out_b[0]), .out_err(out_err[0]), .cnt_total(cnt_total[0]), .cnt_err(cnt_err[0]));
  operand_recover #(.SEL(1)) u_sub (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_y(in_y), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_b(out_b[1]), .out_err(out_err[1]), .cnt_total(cnt_total[1]), .cnt_err(cnt_err[1]));
  operand_recover #(.SEL(5)) u_dflt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_a(in_a), .in_y(in_y), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_b(out_b[2]), .out_err(out_err[2]), .cnt_total(cnt_total[2]), .cnt_err(cnt_err[2]));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: find b such that the forward op maps (a,b) to y; err if none exists in 0..127.
  function automatic logic [7:0] model(int k, int a, int y);
    int d;
    if (k == 1) begin
      d = ((a - y) % 256 + 256) % 256;
      return {(d > 127), 7'(d % 128)};
    end
    d = y - a;
    return {(d < 0 || d > 127), 7'(((d % 128) + 128) % 128)};
  endfunction

  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    acc = in_valid && in_ready[0];
    for (int k = 0; k < 3; k++) begin
      if (out_valid[k] && out_ready) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("spurious_out[%0d]", k), 1, 0);
        end else begin
          e = exp_q[k].pop_front();
          check($sformatf("out_b[%0d]", k), out_b[k], e[6:0]);
          check($sformatf("out_err[%0d]", k), out_err[k], e[7]);
          del[k]++;
          if (e[7]) del_err[k]++;
          if (collect) begin
            got_q[k].push_back({out_err[k], out_b[k]});
            if (k == 0) begin
              if (first_cyc < 0) first_cyc = cyc;
              last_cyc = cyc;
            end
          end
        end
        stalled[k] = 1'b0;
      end else if (out_valid[k]) begin
        if (stalled[k]) check($sformatf("stall_hold[%0d]", k), {out_err[k], out_b[k]}, held[k]);
        stalled[k] = 1'b1;
        held[k]    = {out_err[k], out_b[k]};
      end else begin
        stalled[k] = 1'b0;
      end
      if (in_valid && in_ready[k]) exp_q[k].push_back(model(k, in_a, in_y));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_cnt(string tag);
    for (int k = 0; k < 3; k++) begin
`ifdef OPERAND_RECOVER_STATS_EN
      check($sformatf("%s_total[%0d]", tag, k), cnt_total[k], (del[k] > 65535) ? 65535 : del[k]);
      check($sformatf("%s_err[%0d]", tag, k), cnt_err[k], (del_err[k] > 65535) ? 65535 : del_err[k]);
`else
      check($sformatf("%s_total[%0d]", tag, k), cnt_total[k], 0);
      check($sformatf("%s_err[%0d]", tag, k), cnt_err[k], 0);
`endif
    end
  endtask

  // One isolated transaction with hand-derived results for adder (ba/ea) and subtractor (bs/es).
  task automatic single(logic [6:0] a, logic [7:0] y, logic [6:0] ba, logic ea,
                        logic [6:0] bs, logic es);
    out_ready = 1'b1;
    in_a      = a;
    in_y      = y;
    in_valid  = 1'b1;
    cycle();
    check("single_accept", acc, 1);
    in_valid = 1'b0;
    check("lat_early_valid", out_valid[0], 0);
    cycle();
    for (int k = 0; k < 3; k++) check($sformatf("lat_valid[%0d]", k), out_valid[k], 1);
    check("dir_b_add", out_b[0], ba);
    check("dir_err_add", out_err[0], ea);
    check("dir_b_dflt", out_b[2], ba);
    check("dir_err_dflt", out_err[2], ea);
    check("dir_b_sub", out_b[1], bs);
    check("dir_err_sub", out_err[1], es);
    cycle();
  endtask

  initial begin
    logic [6:0] sa [5];
    logic [7:0] sy [5];
    logic [6:0] ta [20];
    logic [6:0] tb [20];
    int idx;
    int t;

    collect   = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int k = 0; k < 3; k++) begin
      del[k] = 0; del_err[k] = 0; stalled[k] = 1'b0; held[k] = 8'd0;
    end

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 7'd0; in_y = 8'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", in_ready[k], 1);
      check("rst_out_valid", out_valid[k], 0);
      check("rst_out_b", out_b[k], 0);
      check("rst_out_err", out_err[k], 0);
    end
    check_cnt("rst_cnt");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases, including reachability boundaries
    single(7'd100, 8'd150, 7'd50, 1'b0, 7'd78, 1'b1);
    single(7'd100, 8'd50,  7'd78, 1'b1, 7'd50, 1'b0);
`ifdef OPERAND_RECOVER_STATS_EN
    check("first_cnt_total", cnt_total[0], 2);
    check("first_cnt_err", cnt_err[0], 1);
`endif
    single(7'd10,  8'd255, 7'd117, 1'b1, 7'd11, 1'b0);
    single(7'd10,  8'd200, 7'd62,  1'b1, 7'd66, 1'b0);
    single(7'd0,   8'd127, 7'd127, 1'b0, 7'd1,  1'b1);
    check_cnt("dir_cnt");

    // Backpressure: 5 inputs against a stalled consumer
    for (int i = 0; i < 5; i++) begin
      sa[i] = 7'($urandom_range(0, 127));
      sy[i] = 8'($urandom_range(0, 255));
    end
    idx = 0; out_ready = 1'b0; in_valid = 1'b1; in_a = sa[0]; in_y = sy[0];
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (acc) begin
        idx++;
        if (idx < 5) begin in_a = sa[idx]; in_y = sy[idx]; end
      end
    end
    check("bp_accepted", idx, 2);
    for (int k = 0; k < 3; k++) check($sformatf("bp_in_ready_low[%0d]", k), in_ready[k], 0);
    check_cnt("stall_cnt");
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("bp_in_ready_rise[%0d]", k), in_ready[k], 1);
    t = 0;
    while ((idx < 5 || exp_q[0].size() != 0) && t < 30) begin
      cycle();
      if (acc) begin
        idx++;
        if (idx < 5) begin in_a = sa[idx]; in_y = sy[idx]; end
        else in_valid = 1'b0;
      end
      t++;
    end
    check("bp_timeout", (t < 30), 1);
    for (int k = 0; k < 3; k++) check($sformatf("bp_drained[%0d]", k), exp_q[k].size(), 0);
    check_cnt("bp_cnt");

    // Full throughput with y produced by the forward operator
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 20; i++) begin
        ta[i] = 7'($urandom_range(0, 127));
        tb[i] = 7'($urandom_range(0, 127));
      end
      for (int k = 0; k < 3; k++) got_q[k].delete();
      collect = 1'b1; first_cyc = -1; idx = 0; t = 0;
      in_valid = 1'b1; in_a = ta[0];
      in_y = (m == 0) ? 8'({1'b0, ta[0]} + {1'b0, tb[0]}) : 8'({1'b0, ta[0]} - {1'b0, tb[0]});
      while (got_q[0].size() < 20 && t < 60) begin
        cycle();
        if (acc) begin
          idx++;
          if (idx < 20) begin
            in_a = ta[idx];
            in_y = (m == 0) ? 8'({1'b0, ta[idx]} + {1'b0, tb[idx]})
                            : 8'({1'b0, ta[idx]} - {1'b0, tb[idx]});
          end else in_valid = 1'b0;
        end
        t++;
      end
      collect = 1'b0;
      check($sformatf("tput_timeout[%0d]", m), (t < 60), 1);
      check($sformatf("tput_span[%0d]", m), last_cyc - first_cyc, 19);
      for (int k = 0; k < 3; k++) begin
        if ((m == 1) == (k == 1)) begin
          check($sformatf("tput_count[%0d]", k), got_q[k].size(), 20);
          for (int i = 0; i < 20 && i < got_q[k].size(); i++)
            check($sformatf("tput_b[%0d][%0d]", k, i), got_q[k][i], {1'b0, tb[i]});
        end
      end
    end
    check_cnt("tput_cnt");

    // Reset with both stages occupied
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 7'($urandom_range(0, 127)); in_y = 8'($urandom_range(0, 255));
    cycle();
    in_a = 7'($urandom_range(0, 127)); in_y = 8'($urandom_range(0, 255));
    cycle();
    in_valid = 1'b0;
    check("pre_rst_full", in_ready[0], 0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_rst_out_valid[%0d]", k), out_valid[k], 0);
      check($sformatf("mid_rst_in_ready[%0d]", k), in_ready[k], 1);
      exp_q[k].delete();
      del[k] = 0; del_err[k] = 0; stalled[k] = 1'b0;
    end
    check_cnt("mid_rst_cnt");
    @(posedge clk); #1;
    rst = 1'b0;
    single(7'd100, 8'd150, 7'd50, 1'b0, 7'd78, 1'b1);
    check_cnt("post_rst_cnt");

`ifdef OPERAND_RECOVER_STATS_EN
    // Counter saturation after more than 65535 deliveries
    out_ready = 1'b1; in_valid = 1'b1; t = 0;
    while (del[0] < 65540 && t < 70000) begin
      in_a = 7'($urandom_range(0, 127)); in_y = 8'($urandom_range(0, 255));
      cycle();
      t++;
    end
    in_valid = 1'b0;
    check("sat_timeout", (t < 70000), 1);
    check("sat_total", cnt_total[0], 16'hFFFF);
    check_cnt("sat_cnt");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_recover.md
# operand_recover

- Pipelined inverse of the add/subtract datapath: given `a` (7 bits) and the forward result `y` (8 bits), it recovers `b`.
- Each recovered `b` carries an error flag, set when no 7-bit `b` could have produced that `y`.
- It sits at the consumer end of the `top` result stream and checks or decodes `y` against a known `a`.
- Valid/ready handshake on both sides, 2-cycle latency, one result per cycle.

## Interface
Parameters:
- `SEL`, default 0: forward operation being inverted. 0 = adder (`y=a+b`), 1 = subtractor (`y=a-b`). Any other value behaves as 0. Selected with a generate case.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_a`/`in_y` are valid.
- `in_ready`  output  1  block can accept input this cycle.
- `in_a`  input  7  known operand `a`.
- `in_y`  input  8  forward result `y`.
- `out_valid`  output  1  `out_b`/`out_err` are valid.
- `out_ready`  input  1  consumer accepts output this cycle.
- `out_b`  output  7  recovered operand `b`.
- `out_err`  output  1  `y` is not reachable from `a` with any 7-bit `b`.
- `cnt_total`  output  16  results delivered (stats feature).
- `cnt_err`  output  16  results delivered with `out_err=1` (stats feature).

## Operation
- Handshakes:
  - Input is accepted on `in_valid & in_ready`.
  - Output is consumed on `out_valid & out_ready`.
- Stage 1 (S1) registers `a` and `y` with a valid bit.
- Stage 2 (S2) registers the computed `b`, `err` and a valid bit; S2 drives the outputs directly.
- Stage advance:
  - S2 loads when `!S2.valid | out_ready`.
  - S1 loads when `!S1.valid | S2 loads`.
  - `in_ready` = S1 load condition. It is combinational from `out_ready`; there is no combinational path from `in_valid`.
- Arithmetic for `SEL=0`:
  - `d = {1'b0,y} - {2'b0,a}` (9 bits).
  - `b = d[6:0]`, `err = d[8] | d[7]`.
- Arithmetic for `SEL=1`:
  - `d = {1'b0,a} - y` (8 bits, mod 256).
  - `b = d[6:0]`, `err = d[7]`.
- `b` is always the truncated difference, even when `err=1`.
- Output data is held stable while `out_valid & !out_ready`.

## Timing
- Reset values:
  - `in_ready` = 1 (both stages empty).
  - `out_valid` = 0, `out_b` = 0, `out_err` = 0.
  - `cnt_total` = 0, `cnt_err` = 0.
  - S1 data registers = 0.
- Latency: an input accepted at edge N gives `out_valid=1` after edge N+1 (result visible in cycle N+2), provided `out_ready` stays high.
- Throughput: 1 result/cycle with `out_ready` held high. No bubbles are inserted.
- Full pipeline (both stages valid, `out_ready=0`): `in_ready=0`. When `out_ready` rises, `in_ready` rises in the same cycle.
- Simultaneous consume and accept in one cycle: both occur and no data is lost or duplicated.
- Reset asserted mid-operation: both valid bits clear immediately (asynchronously). In-flight results are discarded, never delivered. Counters clear.

## Configuration
- Macro: `OPERAND_RECOVER_STATS_EN`.
- Defined:
  - `cnt_total` increments on every output handshake.
  - `cnt_err` increments on output handshakes with `out_err=1`.
  - Both saturate at 16'hFFFF.
- Undefined: no counter registers; `cnt_total` and `cnt_err` are tied to 0. Ports exist in both builds.

## Test plan
- `SEL=0`, `a=100`, `y=150`, `out_ready=1` → two cycles later `out_b=50`, `out_err=0`. Then `a=100`, `y=50` → `out_b=78`, `out_err=1`.
- `SEL=1`:
  - `a=10`, `y=255` → `out_b=11`, `err=0`.
  - `a=10`, `y=200` → `out_b=66`, `err=0`.
  - `a=0`, `y=127` → `out_b=1`, `err=1`.
- Backpressure: stream 5 inputs with `out_ready=0`.
  - `in_ready` must drop after 2 are accepted.
  - Then raise `out_ready`: all 5 results appear in order, none duplicated or missing.
  - `out_b` stays stable while stalled.
- Full throughput: 20 random pairs produced by the forward `top` (matching `SEL`), `out_ready=1` → 20 consecutive `out_valid` cycles, each `out_b` equal to the original `b`, `out_err=0`.
- Reset mid-stream: assert `rst` while both stages are valid → `out_valid=0` and `in_ready=1` immediately. After release, the next input gives the correct result with 2-cycle latency.
- With `OPERAND_RECOVER_STATS_EN`:
  - After the first scenario: `cnt_total=2`, `cnt_err=1`.
  - A stalled output (`out_valid=1`, `out_ready=0`) does not increment either counter.
  - A counter preloaded near max saturates at 16'hFFFF.
